// File: rtl/transposer_pkg.sv
// Shared state type and default sizing for the MVU bit-plane data transposer.
package transposer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    WRITE
  } tp_state_e;

  localparam int TP_NUM_WORDS = 64;
  localparam int TP_MAX_PREC  = 16;

endpackage

// File: rtl/mvu_data_transposer.sv
// Collects NUM_WORDS scalar elements and writes them to MVU RAM as bit planes.
// Build option MVU_TRANSPOSER_LSB_FIRST_EN puts the LSB plane at the base address.
//
// state   | meaning
// IDLE    | waiting for the first strobe of a batch
// COLLECT | capturing elements 1..NUM_WORDS-1 on each strobe
// WRITE   | issuing one plane write per cycle, then returning to IDLE
module mvu_data_transposer
  import transposer_pkg::*;
#(
  parameter int NUM_WORDS     = TP_NUM_WORDS,
  parameter int XLEN          = 32,
  parameter int MVU_ADDR_LEN  = 15,
  parameter int MVU_DATA_LEN  = TP_NUM_WORDS,
  parameter int MAX_DATA_PREC = TP_MAX_PREC
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [31:0]             prec,
  input  logic [31:0]             baddr,
  input  logic [XLEN-1:0]         iword,
  input  logic                    start,
  output logic                    busy,
  output logic                    mvu_wr_en,
  output logic [MVU_ADDR_LEN-1:0] mvu_wr_addr,
  output logic [MVU_DATA_LEN-1:0] mvu_wr_word
);

  localparam int WCW = $clog2(NUM_WORDS);
  localparam int PW  = $clog2(MAX_DATA_PREC + 1);
  localparam int BW  = $clog2(MAX_DATA_PREC);

  tp_state_e               state;
  logic [WCW-1:0]          w_cnt;
  logic [PW-1:0]           p_cnt;
  logic [PW-1:0]           prec_eff_q;
  logic [PW-1:0]           prec_eff_d;
  logic [MVU_ADDR_LEN-1:0] baddr_q;
  logic [MAX_DATA_PREC-1:0] elem [NUM_WORDS];
  logic [BW-1:0]           bit_sel;
  logic [MVU_DATA_LEN-1:0] plane;
  logic                    unused_in_bits;

  assign unused_in_bits = ^{baddr[31:MVU_ADDR_LEN], iword[XLEN-1:MAX_DATA_PREC]};

  always_comb begin
    prec_eff_d = PW'(prec);
    if (prec == 32'd0) begin
      prec_eff_d = PW'(1);
    end else if (prec > 32'(MAX_DATA_PREC)) begin
      prec_eff_d = PW'(MAX_DATA_PREC);
    end
  end

`ifdef MVU_TRANSPOSER_LSB_FIRST_EN
  assign bit_sel = BW'(p_cnt);
`else
  assign bit_sel = BW'(prec_eff_q - p_cnt - PW'(1));
`endif

  always_comb begin
    plane = '0;
    for (int i = 0; i < NUM_WORDS; i++) begin
      plane[i] = elem[i][bit_sel];
    end
  end

  // Element buffer carries no reset; its contents only matter once a batch is collected.
  always_ff @(posedge clk) begin
    if (start) begin
      if (state == IDLE) begin
        elem[0] <= iword[MAX_DATA_PREC-1:0];
      end else if (state == COLLECT) begin
        elem[w_cnt] <= iword[MAX_DATA_PREC-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      mvu_wr_en   <= 1'b0;
      mvu_wr_addr <= '0;
      mvu_wr_word <= '0;
      w_cnt       <= '0;
      p_cnt       <= '0;
      prec_eff_q  <= PW'(1);
      baddr_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          mvu_wr_en <= 1'b0;
          if (start) begin
            prec_eff_q <= prec_eff_d;
            baddr_q    <= baddr[MVU_ADDR_LEN-1:0];
            w_cnt      <= WCW'(1);
            busy       <= 1'b1;
            state      <= COLLECT;
          end
        end
        COLLECT: begin
          if (start) begin
            if (w_cnt == WCW'(NUM_WORDS - 1)) begin
              w_cnt <= '0;
              p_cnt <= '0;
              state <= WRITE;
            end else begin
              w_cnt <= w_cnt + WCW'(1);
            end
          end
        end
        WRITE: begin
          // One extra cycle after the last plane lets wr_en and busy fall together.
          if (p_cnt < prec_eff_q) begin
            mvu_wr_en   <= 1'b1;
            mvu_wr_addr <= baddr_q + MVU_ADDR_LEN'(p_cnt);
            mvu_wr_word <= plane;
            p_cnt       <= p_cnt + PW'(1);
          end else begin
            mvu_wr_en <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mvu_data_transposer.sv
// Directed/randomized self-checking bench for mvu_data_transposer against a plane model.
module tb_mvu_data_transposer;

  localparam int N    = 64;
  localparam int XLEN = 32;
  localparam int AW   = 15;
  localparam int DW   = 64;
  localparam int MAXP = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [31:0]     prec;
  logic [31:0]     baddr;
  logic [XLEN-1:0] iword;
  logic            busy;
  logic            mvu_wr_en;
  logic [AW-1:0]   mvu_wr_addr;
  logic [DW-1:0]   mvu_wr_word;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [31:0]   elems [N];
  logic [AW-1:0] wr_addr_q [$];
  logic [DW-1:0] wr_word_q [$];
  int            wr_cyc_q  [$];
  logic [DW-1:0] saved_words [$];
  int            busy_low_cyc;

  always #5 clk = ~clk;

  mvu_data_transposer #(
    .NUM_WORDS(N), .XLEN(XLEN), .MVU_ADDR_LEN(AW), .MVU_DATA_LEN(DW), .MAX_DATA_PREC(MAXP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .prec(prec), .baddr(baddr), .iword(iword), .start(start),
    .busy(busy), .mvu_wr_en(mvu_wr_en), .mvu_wr_addr(mvu_wr_addr), .mvu_wr_word(mvu_wr_word)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int eff_prec(input logic [31:0] pr);
    if (pr == 0) return 1;
    if (pr > MAXP) return MAXP;
    return int'(pr);
  endfunction

  // Plane p gathers one chosen bit of every element into a word, element i at bit i.
  function automatic logic [DW-1:0] exp_plane(input int pe, input int p);
    int b;
    logic [DW-1:0] w;
`ifdef MVU_TRANSPOSER_LSB_FIRST_EN
    b = p;
`else
    b = pe - 1 - p;
`endif
    w = '0;
    for (int i = 0; i < N; i++) w[i] = elems[i][b];
    return w;
  endfunction

  function automatic logic [AW-1:0] exp_addr(input logic [31:0] ba, input int p);
    logic [31:0] s;
    s = ba + 32'(p);
    return s[AW-1:0];
  endfunction

  // Called at a negedge; drives the first strobe now and returns at the negedge busy is seen low.
  task automatic run_batch(input logic [31:0] pr, input logic [31:0] ba, input int stall_pct,
                           input bit pulse_in_write, output int stalls);
    int idx, cyc;
    bit done;
    wr_addr_q.delete(); wr_word_q.delete(); wr_cyc_q.delete();
    stalls = 0; busy_low_cyc = -1;
    start = 1'b1; prec = pr; baddr = ba; iword = elems[0];
    idx = 1; cyc = 0; done = 0;
    while (!done && cyc < 600) begin
      @(negedge clk);
      cyc++;
      if (mvu_wr_en === 1'b1) begin
        wr_addr_q.push_back(mvu_wr_addr);
        wr_word_q.push_back(mvu_wr_word);
        wr_cyc_q.push_back(cyc);
      end
      if (busy !== 1'b1) begin
        busy_low_cyc = cyc; done = 1; start = 1'b0;
      end else if (idx < N) begin
        prec = $urandom; baddr = $urandom;
        if ($urandom_range(99) < stall_pct) begin
          start = 1'b0; iword = $urandom; stalls++;
        end else begin
          start = 1'b1; iword = elems[idx]; idx++;
        end
      end else begin
        start = pulse_in_write ? 1'($urandom_range(1)) : 1'b0;
        iword = $urandom;
      end
    end
  endtask

  task automatic verify_batch(input string tag, input logic [31:0] pr, input logic [31:0] ba,
                              input int stalls);
    int pe;
    pe = eff_prec(pr);
    check({tag, " latency"}, 64'(busy_low_cyc), 64'(N + pe + 1 + stalls));
    check({tag, " nwrites"}, 64'(wr_addr_q.size()), 64'(pe));
    for (int p = 0; p < pe && p < wr_addr_q.size(); p++) begin
      check({tag, " addr"}, 64'(wr_addr_q[p]), 64'(exp_addr(ba, p)));
      check({tag, " word"}, 64'(wr_word_q[p]), 64'(exp_plane(pe, p)));
      check({tag, " wcycle"}, 64'(wr_cyc_q[p]), 64'(N + 1 + stalls + p));
    end
    check({tag, " en_low"}, 64'(mvu_wr_en), 64'(0));
    check({tag, " hold_addr"}, 64'(mvu_wr_addr), 64'(exp_addr(ba, pe - 1)));
    check({tag, " hold_word"}, 64'(mvu_wr_word), 64'(exp_plane(pe, pe - 1)));
  endtask

  initial begin
    int st, nw, k;
    logic [31:0] base;

    rst_n = 1'b0; start = 1'b1; prec = 32'd2; baddr = 32'h100; iword = '1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst busy", 64'(busy), 64'(0));
      check("rst wr_en", 64'(mvu_wr_en), 64'(0));
    end
    check("rst addr", 64'(mvu_wr_addr), 64'(0));
    check("rst word", 64'(mvu_wr_word), 64'(0));
    rst_n = 1'b1; start = 1'b0;
    @(negedge clk);
    check("idle busy", 64'(busy), 64'(0));

    for (int i = 0; i < N; i++) elems[i] = 32'(i % 4);
    run_batch(32'd2, 32'h100, 0, 0, st);
    verify_batch("p2", 32'd2, 32'h100, st);
    if (wr_word_q.size() == 2) begin
`ifdef MVU_TRANSPOSER_LSB_FIRST_EN
      check("p2 const0", 64'(wr_word_q[0]), 64'hAAAA_AAAA_AAAA_AAAA);
      check("p2 const1", 64'(wr_word_q[1]), 64'hCCCC_CCCC_CCCC_CCCC);
`else
      check("p2 const0", 64'(wr_word_q[0]), 64'hCCCC_CCCC_CCCC_CCCC);
      check("p2 const1", 64'(wr_word_q[1]), 64'hAAAA_AAAA_AAAA_AAAA);
`endif
    end

    for (int i = 0; i < N; i++) elems[i] = 32'hFFFF_FFFF;
    run_batch(32'd1, 32'h7FFF, 0, 0, st);
    verify_batch("wrap1", 32'd1, 32'h7FFF, st);
    run_batch(32'd2, 32'h7FFF, 0, 0, st);
    verify_batch("wrap2", 32'd2, 32'h7FFF, st);
    if (wr_addr_q.size() == 2) check("wrap2 addr0", 64'(wr_addr_q[1]), 64'(0));

    for (int i = 0; i < N; i++) elems[i] = $urandom;
    base = $urandom;
    run_batch(32'd8, base, 0, 0, st);
    verify_batch("p8 nogap", 32'd8, base, st);
    saved_words = wr_word_q;
    run_batch(32'd8, base, 40, 1, st);
    verify_batch("p8 stall", 32'd8, base, st);
    check("p8 stall count", 64'(wr_word_q.size()), 64'(saved_words.size()));
    for (int p = 0; p < wr_word_q.size() && p < saved_words.size(); p++)
      check("p8 stall same", 64'(wr_word_q[p]), 64'(saved_words[p]));

    for (int i = 0; i < N; i++) elems[i] = $urandom;
    base = $urandom;
    run_batch(32'd0, base, 0, 0, st);
    verify_batch("clamp0", 32'd0, base, st);
    for (int i = 0; i < N; i++) elems[i] = $urandom;
    base = $urandom;
    run_batch(32'd20, base, 10, 1, st);
    verify_batch("clamp20", 32'd20, base, st);

    // Abort during the third plane write of a prec=8 batch.
    for (int i = 0; i < N; i++) elems[i] = $urandom;
    start = 1'b1; prec = 32'd8; baddr = 32'h0040; iword = elems[0];
    for (int i = 1; i < N; i++) begin
      @(negedge clk);
      iword = elems[i];
    end
    @(negedge clk);
    start = 1'b0;
    nw = 0; k = 0;
    while (nw < 3 && k < 20) begin
      @(negedge clk);
      k++;
      if (mvu_wr_en === 1'b1) nw++;
    end
    check("abort writes_before", 64'(nw), 64'(3));
    rst_n = 1'b0;
    @(negedge clk);
    check("abort wr_en", 64'(mvu_wr_en), 64'(0));
    check("abort busy", 64'(busy), 64'(0));
    rst_n = 1'b1;
    nw = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (mvu_wr_en !== 1'b0) nw++;
    end
    check("abort no_writes", 64'(nw), 64'(0));

    for (int i = 0; i < N; i++) elems[i] = $urandom;
    base = $urandom;
    run_batch(32'd8, base, 20, 1, st);
    verify_batch("after abort", 32'd8, base, st);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
